eth_header_framer: RTL and testbench
====================================

Name: eth_header_framer

Overview:
Streaming Ethernet TX framer. Latches destination MAC, source MAC, EtherType and an optional 802.1Q tag at frame start, and emits the header bytes in network order on a byte-wide valid/ready stream. It then passes the payload through and zero-pads it to the Ethernet minimum. Sits between the payload source (e.g. IPv4/UDP builder) and the FCS/MAC TX block, replacing the static combinational header generator.

Parameters:
VLAN_EN, 0, 1 = insert 802.1Q tag (TPID 0x8100 + vlan_tci); header is 18 bytes instead of 14.
PAD_EN, 1, 1 = zero-pad payload up to MIN_PAYLOAD bytes; 0 = no padding.
MIN_PAYLOAD, 46, minimum payload byte count when PAD_EN=1. Range 1..1500.
CNT_W, 16, width of internal payload byte counter. Saturates, never wraps.

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
dst_mac  in  48  destination MAC; bits [47:40] are transmitted first
src_mac  in  48  source MAC; bits [47:40] are transmitted first
ethertype  in  16  EtherType/length; bits [15:8] are transmitted first
vlan_tci  in  16  802.1Q TCI; used only when VLAN_EN=1
s_tdata  in  8  payload byte
s_tvalid  in  1  payload byte valid
s_tlast  in  1  last payload byte of frame
s_tready  out  1  payload accepted when s_tvalid && s_tready
m_tdata  out  8  framed output byte
m_tvalid  out  1  output byte valid
m_tlast  out  1  last byte of framed output
m_tready  in  1  downstream ready
busy  out  1  high from header start until the last output byte is accepted
frame_count  out  32  completed frames; wraps modulo 2^32

Behaviour:
- Clock and reset are fixed: one clock, clk; rst is asynchronous and active-high.
- Reset values: state=IDLE; m_tvalid=0, m_tlast=0, m_tdata=0, s_tready=0, busy=0, frame_count=0, all counters 0.
- States: IDLE, HEADER, PAYLOAD, PAD.
- IDLE:
  - s_tready=0, m_tvalid=0.
  - On a cycle with s_tvalid=1: latch dst_mac, src_mac, ethertype, vlan_tci; clear hdr_idx and pay_cnt; go to HEADER.
  - The first header byte is valid on the following cycle (1-cycle latency).
- HEADER:
  - m_tvalid=1, s_tready=0, m_tlast=0.
  - m_tdata = latched header byte hdr_idx. Order: dst[47:40]..dst[7:0], src[47:40]..src[7:0], [0x81, 0x00, tci[15:8], tci[7:0] if VLAN_EN], ethertype[15:8], ethertype[7:0].
  - hdr_idx advances only on m_tvalid && m_tready.
  - Acceptance of the last header byte (index 13, or 17 with VLAN) moves to PAYLOAD.
- PAYLOAD (combinational pass-through):
  - m_tdata=s_tdata, m_tvalid=s_tvalid, s_tready=m_tready.
  - Each accepted beat increments pay_cnt (saturating at 2^CNT_W-1).
  - On an accepted beat with s_tlast: if PAD_EN && pay_cnt+1 < MIN_PAYLOAD, then m_tlast=0 and go to PAD. Otherwise m_tlast=1, go to IDLE, and frame_count increments.
- PAD:
  - m_tvalid=1, m_tdata=0x00, s_tready=0.
  - pay_cnt increments per accepted beat.
  - m_tlast=1 on the beat where pay_cnt == MIN_PAYLOAD-1. Its acceptance returns to IDLE and increments frame_count.
- Handshake: while m_tvalid=1 and m_tready=0, m_tdata and m_tlast hold stable. No bubbles are inserted by the block in HEADER or PAD.
- Config inputs are sampled only on the IDLE->HEADER transition; changes mid-frame have no effect on the current frame.
- A payload frame of exactly MIN_PAYLOAD bytes produces no pad. A 1-byte payload produces MIN_PAYLOAD-1 pad bytes.
- Frames longer than 2^CNT_W-1 pass unmodified: counter saturation only affects padding.
- Back-to-back frames: after the final beat is accepted, IDLE needs one cycle before the next header starts (1 idle cycle minimum gap).
- Reset asserted mid-frame: everything returns immediately to reset values and the partial frame is abandoned. Downstream must discard the incomplete frame (no m_tlast is produced).
- busy = (state != IDLE).

Decomposition:
- ethernet_header_pkg additions:
  - ETH_HDR_BYTES=14, ETH_VLAN_HDR_BYTES=18, ETH_MIN_PAYLOAD=46, TPID_VLAN=16'h8100.
  - typedef enum framer_state_t {IDLE, HEADER, PAYLOAD, PAD}.
  - typedef vlan_tag struct (tpid, tci).
- One sub-module: eth_header_byte_sel. Combinational; maps the latched header fields plus hdr_idx to one byte, parameterised by VLAN_EN.

Test Plan:
- Basic frame: dst=e86a64e7e829, src=e86a64e7e830, ethertype=0x0080, VLAN_EN=0, 60-byte payload 0x00..0x3B, m_tready=1 -> output e8 6a 64 e7 e8 29 e8 6a 64 e7 e8 30 00 80, then payload unchanged; m_tlast on byte 74 only; frame_count=1.
- Padding: 10-byte payload 0xA0..0xA9 -> 14 header bytes, 10 payload bytes, 36 bytes of 0x00; m_tlast on byte 60 total; s_tready=0 during pad.
- VLAN: VLAN_EN=1, vlan_tci=0x6064, ethertype=0x0800 -> bytes 12..17 are 81 00 60 64 08 00; a 46-byte payload gives no pad, 64 bytes total.
- Backpressure: m_tready toggles 1,0,0,1 during the header and pad phases -> m_tdata/m_tlast stable while stalled; no byte lost or duplicated; byte count equals the m_tready=1 case.
- Config stability: change dst_mac to ffffffffffff after the second header byte -> the remaining header still uses the latched e86a64e7e829; the next frame uses ffffffffffff.
- Reset mid-payload: assert rst asynchronously at payload byte 5 -> m_tvalid=0, busy=0, frame_count unchanged immediately; the next frame after reset starts with a full header.

Source files
------------

// File: rtl/eth_header_framer_pkg.sv
// eth_header_framer_pkg: shared constants, FSM states and VLAN tag layout for the Ethernet TX framer.
package eth_header_framer_pkg;
  localparam int ETH_HDR_BYTES = 14;
  localparam int ETH_VLAN_HDR_BYTES = 18;
  localparam int ETH_MIN_PAYLOAD = 46;
  localparam logic [15:0] TPID_VLAN = 16'h8100;
  typedef enum logic [1:0] {IDLE, HEADER, PAYLOAD, PAD} framer_state_t;
  typedef struct packed {
    logic [15:0] tpid;
    logic [15:0] tci;
  } vlan_tag_t;
endpackage

// File: rtl/eth_header_byte_sel.sv
// eth_header_byte_sel: picks header byte hdr_idx (network order) from the latched header fields.
module eth_header_byte_sel
  import eth_header_framer_pkg::*;
#(
  parameter bit VLAN_EN = 1'b0
) (
  input  logic [47:0] dst_mac,
  input  logic [47:0] src_mac,
  input  logic [15:0] ethertype,
  input  logic [15:0] vlan_tci,
  input  logic [4:0]  hdr_idx,
  output logic [7:0]  hdr_byte
);
  vlan_tag_t tag;
  logic [143:0] hdr;
  logic [4:0] idx;
  assign tag = '{tpid: TPID_VLAN, tci: vlan_tci};
  assign hdr = {dst_mac, src_mac, tag, ethertype};
  // Untagged frames skip the four tag bytes so the EtherType follows the source MAC.
  assign idx = (!VLAN_EN && hdr_idx >= 5'd12) ? hdr_idx + 5'd4 : hdr_idx;
  assign hdr_byte = 8'(hdr >> {5'd17 - idx, 3'b000});
endmodule

// File: rtl/eth_header_framer.sv
// eth_header_framer: prepends an Ethernet (optionally 802.1Q) header to a byte stream
// and zero-pads short payloads to the Ethernet minimum.
module eth_header_framer
  import eth_header_framer_pkg::*;
#(
  parameter bit VLAN_EN     = 1'b0,
  parameter bit PAD_EN      = 1'b1,
  parameter int MIN_PAYLOAD = ETH_MIN_PAYLOAD,
  parameter int CNT_W       = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [47:0] dst_mac,
  input  logic [47:0] src_mac,
  input  logic [15:0] ethertype,
  input  logic [15:0] vlan_tci,
  input  logic [7:0]  s_tdata,
  input  logic        s_tvalid,
  input  logic        s_tlast,
  output logic        s_tready,
  output logic [7:0]  m_tdata,
  output logic        m_tvalid,
  output logic        m_tlast,
  input  logic        m_tready,
  output logic        busy,
  output logic [31:0] frame_count
);
  localparam logic [4:0] HDR_LAST = VLAN_EN ? 5'(ETH_VLAN_HDR_BYTES - 1) : 5'(ETH_HDR_BYTES - 1);
  localparam logic [31:0] MIN_M1 = 32'(MIN_PAYLOAD - 1);
  framer_state_t state, state_nxt;
  logic [4:0] hdr_idx;
  logic [CNT_W-1:0] pay_cnt, cnt_inc;
  logic [47:0] dst_q, src_q;
  logic [15:0] et_q, tci_q;
  logic [7:0] hdr_byte;
  logic need_pad, pad_last, acc;
  eth_header_byte_sel #(.VLAN_EN(VLAN_EN)) u_sel (
    .dst_mac(dst_q), .src_mac(src_q), .ethertype(et_q), .vlan_tci(tci_q),
    .hdr_idx(hdr_idx), .hdr_byte(hdr_byte)
  );
  assign cnt_inc = &pay_cnt ? pay_cnt : pay_cnt + 1'b1;
  // pay_cnt+1 < MIN_PAYLOAD rewritten to avoid overflow at saturation.
  assign need_pad = PAD_EN && (32'(pay_cnt) < MIN_M1);
  assign pad_last = 32'(pay_cnt) == MIN_M1;
  assign acc = m_tvalid && m_tready;
  assign busy = state != IDLE;
  always_comb begin
    state_nxt = state;
    m_tvalid = 1'b0;
    m_tdata = 8'h00;
    m_tlast = 1'b0;
    s_tready = 1'b0;
    case (state)
      IDLE: state_nxt = s_tvalid ? HEADER : IDLE;
      HEADER: begin
        m_tvalid = 1'b1;
        m_tdata = hdr_byte;
        state_nxt = (m_tready && hdr_idx == HDR_LAST) ? PAYLOAD : HEADER;
      end
      PAYLOAD: begin
        m_tvalid = s_tvalid;
        m_tdata = s_tdata;
        s_tready = m_tready;
        m_tlast = s_tlast && !need_pad;
        state_nxt = (s_tvalid && m_tready && s_tlast) ? (need_pad ? PAD : IDLE) : PAYLOAD;
      end
      PAD: begin
        m_tvalid = 1'b1;
        m_tlast = pad_last;
        state_nxt = (m_tready && pad_last) ? IDLE : PAD;
      end
      default: state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      hdr_idx <= '0;
      pay_cnt <= '0;
      dst_q <= '0;
      src_q <= '0;
      et_q <= '0;
      tci_q <= '0;
      frame_count <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && s_tvalid) begin
        dst_q <= dst_mac;
        src_q <= src_mac;
        et_q <= ethertype;
        tci_q <= vlan_tci;
        hdr_idx <= '0;
        pay_cnt <= '0;
      end
      if (state == HEADER && acc) hdr_idx <= hdr_idx + 5'd1;
      if ((state == PAYLOAD || state == PAD) && acc) pay_cnt <= cnt_inc;
      if (acc && m_tlast) frame_count <= frame_count + 32'd1;
    end
  end
endmodule

// File: tb/tb_eth_header_framer.sv
// tb_eth_header_framer: randomized framing checks for untagged and VLAN framers against a byte-queue model.
module tb_eth_header_framer;
  logic clk = 1'b0, rst, sel;
  logic [47:0] dst_mac, src_mac;
  logic [15:0] ethertype, vlan_tci;
  logic [7:0] s_tdata;
  logic s_tvalid, s_tlast, m_tready;
  logic s_tvalid_a, s_tvalid_b, s_tready_a, s_tready_b, m_tvalid_a, m_tvalid_b;
  logic m_tlast_a, m_tlast_b, busy_a, busy_b;
  logic [7:0] m_tdata_a, m_tdata_b;
  logic [31:0] frame_count_a, frame_count_b;
  logic s_tready, m_tvalid, m_tlast, busy;
  logic [7:0] m_tdata;
  logic [31:0] frame_count;
  int n_cmp = 0, n_err = 0;
  int exp_fc[2] = '{0, 0};
  always #5 clk = ~clk;
  assign s_tvalid_a = s_tvalid & ~sel;
  assign s_tvalid_b = s_tvalid & sel;
  assign s_tready = sel ? s_tready_b : s_tready_a;
  assign m_tvalid = sel ? m_tvalid_b : m_tvalid_a;
  assign m_tlast = sel ? m_tlast_b : m_tlast_a;
  assign m_tdata = sel ? m_tdata_b : m_tdata_a;
  assign busy = sel ? busy_b : busy_a;
  assign frame_count = sel ? frame_count_b : frame_count_a;
  eth_header_framer #(.VLAN_EN(1'b0)) u_dut (
    .clk(clk), .rst(rst), .dst_mac(dst_mac), .src_mac(src_mac), .ethertype(ethertype),
    .vlan_tci(vlan_tci), .s_tdata(s_tdata), .s_tvalid(s_tvalid_a), .s_tlast(s_tlast),
    .s_tready(s_tready_a), .m_tdata(m_tdata_a), .m_tvalid(m_tvalid_a), .m_tlast(m_tlast_a),
    .m_tready(m_tready), .busy(busy_a), .frame_count(frame_count_a)
  );
  eth_header_framer #(.VLAN_EN(1'b1)) u_vlan (
    .clk(clk), .rst(rst), .dst_mac(dst_mac), .src_mac(src_mac), .ethertype(ethertype),
    .vlan_tci(vlan_tci), .s_tdata(s_tdata), .s_tvalid(s_tvalid_b), .s_tlast(s_tlast),
    .s_tready(s_tready_b), .m_tdata(m_tdata_b), .m_tvalid(m_tvalid_b), .m_tlast(m_tlast_b),
    .m_tready(m_tready), .busy(busy_b), .frame_count(frame_count_b)
  );
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic run_frame(input bit vl, input int len, input int base, input int rdy_pct,
                           input int val_pct, input bit chg, input int abort_at);
    logic [7:0] exp_q[$];
    logic [7:0] pay[$];
    int hn, si, got, cyc;
    logic [7:0] prev_d;
    logic prev_l, stall, sa;
    hn = vl ? 18 : 14;
    si = 0; got = 0; cyc = 0; stall = 1'b0; prev_d = '0; prev_l = 1'b0;
    sel = vl;
    for (int i = 0; i < len; i++) pay.push_back(base < 0 ? 8'($urandom) : 8'(base + i));
    for (int i = 0; i < 6; i++) exp_q.push_back(dst_mac[47-8*i -: 8]);
    for (int i = 0; i < 6; i++) exp_q.push_back(src_mac[47-8*i -: 8]);
    if (vl) begin
      exp_q.push_back(8'h81); exp_q.push_back(8'h00);
      exp_q.push_back(vlan_tci[15:8]); exp_q.push_back(vlan_tci[7:0]);
    end
    exp_q.push_back(ethertype[15:8]); exp_q.push_back(ethertype[7:0]);
    foreach (pay[i]) exp_q.push_back(pay[i]);
    while (exp_q.size() < hn + 46) exp_q.push_back(8'h00);
    while (got < exp_q.size() && cyc < 5000) begin
      if (!s_tvalid && si < len && $urandom_range(99) < val_pct) begin
        s_tvalid = 1'b1; s_tdata = pay[si]; s_tlast = (si == len - 1);
      end
      m_tready = rdy_pct < 0 ? (cyc % 4 == 0 || cyc % 4 == 3) : ($urandom_range(99) < rdy_pct);
      #1;
      if (cyc == 0) check("first_cycle_idle", m_tvalid, 0);
      if (stall) begin
        check("stall_hold_data", m_tdata, prev_d);
        check("stall_hold_last", m_tlast, prev_l);
      end
      if (m_tvalid && (got < hn || got >= hn + len)) check("s_tready_low", s_tready, 0);
      if (got > 0 && got < exp_q.size()) check("busy_mid", busy, 1);
      if (m_tvalid && m_tready) begin
        check($sformatf("byte%0d", got), m_tdata, exp_q[got]);
        check($sformatf("last%0d", got), m_tlast, got == exp_q.size() - 1);
        got++;
      end
      stall = m_tvalid && !m_tready;
      prev_d = m_tdata; prev_l = m_tlast;
      sa = s_tvalid && s_tready;
      if (chg && got == 2) dst_mac = '1;
      if (abort_at >= 0 && got == hn + abort_at) begin
        rst = 1'b1;
        #1;
        check("rst_m_tvalid", m_tvalid, 0);
        check("rst_m_tlast", m_tlast, 0);
        check("rst_busy", busy, 0);
        check("rst_frame_count", frame_count, 0);
        exp_fc = '{0, 0};
        s_tvalid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        return;
      end
      @(negedge clk);
      if (sa) begin si++; s_tvalid = 1'b0; end
      cyc++;
    end
    check("frame_complete", got, exp_q.size());
    s_tvalid = 1'b0; m_tready = 1'b0;
    exp_fc[vl]++;
    #1;
    check("end_busy", busy, 0);
    check("end_m_tvalid", m_tvalid, 0);
    check("end_frame_count", frame_count, exp_fc[vl]);
    @(negedge clk);
  endtask
  task automatic set_basic();
    dst_mac = 48'he86a64e7e829; src_mac = 48'he86a64e7e830;
    ethertype = 16'h0080; vlan_tci = 16'h0000;
  endtask
  initial begin
    rst = 1'b1; sel = 1'b0; s_tvalid = 1'b0; s_tdata = '0; s_tlast = 1'b0; m_tready = 1'b0;
    set_basic();
    repeat (3) @(negedge clk);
    #1;
    check("rst_a_m_tvalid", m_tvalid_a, 0);
    check("rst_a_m_tdata", m_tdata_a, 0);
    check("rst_a_m_tlast", m_tlast_a, 0);
    check("rst_a_s_tready", s_tready_a, 0);
    check("rst_a_busy", busy_a, 0);
    check("rst_a_frame_count", frame_count_a, 0);
    check("rst_b_busy", busy_b, 0);
    check("rst_b_frame_count", frame_count_b, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_frame(0, 20, 0, 100, 100, 0, 5);
    run_frame(0, 60, 0, 100, 100, 0, -1);
    run_frame(0, 10, 'hA0, 100, 100, 0, -1);
    dst_mac = 48'h020000000001; vlan_tci = 16'h6064; ethertype = 16'h0800;
    run_frame(1, 46, 0, 100, 100, 0, -1);
    set_basic();
    run_frame(0, 10, 'hA0, -1, 100, 0, -1);
    run_frame(1, 10, 'hA0, -1, 100, 0, -1);
    run_frame(0, 20, 0, 70, 80, 1, -1);
    run_frame(0, 20, 0, 70, 80, 0, -1);
    run_frame(0, 1, 'h55, 60, 100, 0, -1);
    run_frame(0, 46, -1, 60, 70, 0, -1);
    run_frame(0, 47, -1, 60, 70, 0, -1);
    run_frame(1, 45, -1, 60, 70, 0, -1);
    for (int k = 0; k < 20; k++) begin
      dst_mac = {$urandom, $urandom}; src_mac = {$urandom, $urandom};
      ethertype = 16'($urandom); vlan_tci = 16'($urandom);
      run_frame(1'($urandom), $urandom_range(1, 80), -1, $urandom_range(40, 100),
                $urandom_range(40, 100), 1'($urandom), -1);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
